// File: rtl/count_chk_pkg.sv
// rtl/count_chk_pkg.sv - shared types and sizing helpers for the counter sequence checker
package count_chk_pkg;

   typedef enum logic {
      ACQUIRE = 1'b0,
      LOCKED  = 1'b1
   } chk_state_e;

   // Wide enough to hold the value LOCK_N itself, not just LOCK_N-1.
   function automatic int LOCK_CNT_W(input int lock_n);
      return $clog2(lock_n + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear taking priority over increment
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - locks onto a free-running counter stream and counts discontinuities
module count_seq_checker
   import count_chk_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int LOCK_N = 4,
   parameter int ERR_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dut_rst,
   input  logic             cnt_valid,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             clr_err,
   output logic             locked,
   output logic             err_pulse,
   output logic             sticky_err,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] expected
);

   localparam int              MC_W     = LOCK_CNT_W(LOCK_N);
   localparam logic [MC_W-1:0] LOCK_TGT = MC_W'(LOCK_N);

   chk_state_e       r_state,     w_state_nxt;
   logic             r_seeded,    w_seeded_nxt;
   logic [MC_W-1:0]  r_match_cnt, w_match_cnt_nxt;
   logic [WIDTH-1:0] r_expected,  w_expected_nxt;
   logic             r_err_pulse, w_err_pulse_nxt;
   logic             r_sticky,    w_sticky_nxt;
   logic             r_dut_rst_q;
   logic             w_eval;
   logic             w_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ACQUIRE;
         r_seeded    <= 1'b0;
         r_match_cnt <= '0;
         r_expected  <= '0;
         r_err_pulse <= 1'b0;
         r_sticky    <= 1'b0;
         r_dut_rst_q <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_seeded    <= w_seeded_nxt;
         r_match_cnt <= w_match_cnt_nxt;
         r_expected  <= w_expected_nxt;
         r_err_pulse <= w_err_pulse_nxt;
         r_sticky    <= w_sticky_nxt;
         r_dut_rst_q <= dut_rst;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_seeded_nxt    = r_seeded;
      w_match_cnt_nxt = r_match_cnt;
      w_expected_nxt  = r_expected;
      w_err_pulse_nxt = 1'b0;
      w_eval          = 1'b0;
      w_hit           = 1'b0;
      if (cnt_valid) begin
         // Right after a counter reset only a zero sample is meaningful; anything else just reseeds.
         w_eval         = !r_dut_rst_q || (cnt_in == '0);
         w_hit          = (cnt_in == r_expected) || (r_dut_rst_q && (cnt_in == '0));
         w_expected_nxt = cnt_in + WIDTH'(1);
         if (r_state == ACQUIRE) begin
            if (!r_seeded) begin
               w_seeded_nxt    = 1'b1;
               w_match_cnt_nxt = '0;
            end else if (w_eval) begin
               if (!w_hit) begin
                  w_match_cnt_nxt = '0;
               end else if (r_match_cnt + MC_W'(1) == LOCK_TGT) begin
                  w_state_nxt     = LOCKED;
                  w_match_cnt_nxt = '0;
               end else begin
                  w_match_cnt_nxt = r_match_cnt + MC_W'(1);
               end
            end
         end else if (w_eval && !w_hit) begin
            // The offending sample becomes the new seed, so reacquire starts at one sample in.
            w_err_pulse_nxt = 1'b1;
            w_state_nxt     = ACQUIRE;
            w_match_cnt_nxt = '0;
         end
         if (dut_rst) begin
            w_expected_nxt = '0;
         end
      end
      w_sticky_nxt = clr_err ? 1'b0 : (r_sticky | w_err_pulse_nxt);
   end

   sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_err_pulse_nxt),
      .i_clr   (clr_err),
      .o_count (err_count)
   );

   assign locked     = (r_state == LOCKED);
   assign err_pulse  = r_err_pulse;
   assign sticky_err = r_sticky;
   assign expected   = r_expected;

endmodule
